// File: rtl/rfdc_dds_capture.sv
// ============================================================================
// rfdc_dds_capture
// ----------------------------------------------------------------------------
// Timestamp-triggered capture buffer for the 256-bit DDS sample stream
// (16 x 16-bit signed samples per beat, lane 0 oldest). The block observes
// the stream beside the DAC datapath and never drives the DAC.
//
// Flow: IDLE --arm--> ARMED --(tvalid && timestamp >= trigger_time)-->
//       CAPTURE --(len_eff beats stored)--> DONE --> READ --(tlast taken)--> IDLE
//       abort returns to IDLE from any state.
//
// Ports
//   s_axi_aclk, s_axi_aresetn   sole clock, synchronous active-low reset
//   s_axis_*                    DDS stream sink (always ready after reset)
//   timestamp                   free-running system time
//   arm / abort                 one-cycle control pulses (abort wins)
//   trigger_time, capture_len   capture setup, sampled on arm
//   busy, done                  status (ARMED|CAPTURE, DONE|READ)
//   trig_timestamp              timestamp of captured beat 0
//   gap_count                   tvalid-low cycles during capture (saturating)
//   m_rd_*                      readback stream of the captured beats
//
// Optional feature: define CAPTURE_PEAK_EN to add output peak_abs[15:0], the
// largest |sample| over all lanes of all captured beats (-32768 reads 32767).
// ============================================================================
module rfdc_dds_capture #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TS_W   = 64
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [255:0]      s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [TS_W-1:0]   timestamp,
  input  logic              arm,
  input  logic              abort,
  input  logic [TS_W-1:0]   trigger_time,
  input  logic [ADDR_W:0]   capture_len,
  output logic              busy,
  output logic              done,
  output logic [TS_W-1:0]   trig_timestamp,
  output logic [15:0]       gap_count,
  output logic [255:0]      m_rd_tdata,
  output logic              m_rd_tvalid,
  input  logic              m_rd_tready,
  output logic              m_rd_tlast
`ifdef CAPTURE_PEAK_EN
  ,
  output logic [15:0]       peak_abs
`endif
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE,
    S_READ
  } state_t;

  state_t            state_q,     state_d;
  logic              tready_q,    tready_d;
  logic [TS_W-1:0]   trig_time_q, trig_time_d;
  logic [ADDR_W:0]   len_q,       len_d;
  logic [ADDR_W:0]   wr_ptr_q,    wr_ptr_d;
  logic [TS_W-1:0]   trig_ts_q,   trig_ts_d;
  logic [15:0]       gap_q,       gap_d;
  logic [ADDR_W:0]   rd_ptr_q,    rd_ptr_d;
  logic              ram_vld_q,   ram_vld_d;
  logic              ram_last_q,  ram_last_d;
  logic              out_vld_q,   out_vld_d;
  logic [255:0]      out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [255:0]      ram_data_q;
  logic              out_adv;
  logic              ram_free;

  logic [255:0]      mem [DEPTH];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    tready_d    = 1'b1;
    trig_time_d = trig_time_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    trig_ts_d   = trig_ts_q;
    gap_d       = gap_q;
    rd_ptr_d    = rd_ptr_q;
    ram_vld_d   = ram_vld_q;
    ram_last_d  = ram_last_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q[ADDR_W-1:0];
    mem_ren     = 1'b0;
    mem_raddr   = rd_ptr_q[ADDR_W-1:0];
    out_adv     = !out_vld_q || m_rd_tready;
    ram_free    = !ram_vld_q || out_adv;

    if (abort) begin
      // Captured data and statistics are kept; only the readback is dropped.
      state_d   = S_IDLE;
      out_vld_d = 1'b0;
      ram_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d     = S_ARMED;
            trig_time_d = trigger_time;
            len_d       = (capture_len == '0 || capture_len > DEPTH_L) ? DEPTH_L : capture_len;
            gap_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
          end
        end

        S_ARMED: begin
          if (s_axis_tvalid && (timestamp >= trig_time_q)) begin
            mem_we    = 1'b1;
            mem_waddr = '0;
            trig_ts_d = timestamp;
            wr_ptr_d  = ONE;
            state_d   = (len_q == ONE) ? S_DONE : S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          // The cycle after the final write is spent here; its beat is
          // discarded and it is not counted as a gap.
          if (wr_ptr_q == len_q) begin
            state_d = S_DONE;
          end else if (s_axis_tvalid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
          end else if (gap_q != '1) begin
            gap_d = gap_q + 16'd1;
          end
        end

        S_DONE, S_READ: begin
          // Two-entry prefetch: RAM output register feeds the output
          // register, and the RAM refills whenever its entry is consumed,
          // giving one beat per cycle while the consumer keeps tready high.
          if (out_adv) begin
            out_vld_d = ram_vld_q;
            if (ram_vld_q) begin
              out_data_d = ram_data_q;
              out_last_d = ram_last_q;
            end
          end
          if (ram_free) begin
            if (rd_ptr_q != len_q) begin
              mem_ren    = 1'b1;
              ram_vld_d  = 1'b1;
              ram_last_d = (rd_ptr_q == len_q - ONE);
              rd_ptr_d   = rd_ptr_q + ONE;
            end else begin
              ram_vld_d = 1'b0;
            end
          end
          if (out_vld_q && m_rd_tready && out_last_q) begin
            state_d   = S_IDLE;
            out_vld_d = 1'b0;
            ram_vld_d = 1'b0;
          end else begin
            state_d = S_READ;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q     <= S_IDLE;
      tready_q    <= 1'b0;
      trig_time_q <= '0;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      trig_ts_q   <= '0;
      gap_q       <= '0;
      rd_ptr_q    <= '0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      trig_time_q <= trig_time_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_ts_q   <= trig_ts_d;
      gap_q       <= gap_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Capture buffer: one write port, one registered read port
  // --------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk) begin
    if (mem_we) begin
      mem[mem_waddr] <= s_axis_tdata;
    end
    if (mem_ren) begin
      ram_data_q <= mem[mem_raddr];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axis_tready  = tready_q;
  assign busy           = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done           = (state_q == S_DONE)  || (state_q == S_READ);
  assign trig_timestamp = trig_ts_q;
  assign gap_count      = gap_q;
  assign m_rd_tdata     = out_data_q;
  assign m_rd_tvalid    = out_vld_q;
  assign m_rd_tlast     = out_last_q;

`ifdef CAPTURE_PEAK_EN
  // --------------------------------------------------------------------------
  // Peak magnitude tracker
  // --------------------------------------------------------------------------
  logic        arm_take;
  logic [15:0] beat_max;
  logic [15:0] peak_q, peak_d;

  function automatic logic [15:0] lane_abs(input logic [15:0] s);
    if (s == 16'h8000) begin
      return 16'h7fff;
    end else if (s[15]) begin
      return -s;
    end else begin
      return s;
    end
  endfunction

  assign arm_take = (state_q == S_IDLE) && arm && !abort;

  // Folded at the write edge so the final peak is registered by the time
  // done rises, including a single-beat capture that skips CAPTURE.
  always_comb begin
    beat_max = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      if (lane_abs(s_axis_tdata[16*k +: 16]) > beat_max) begin
        beat_max = lane_abs(s_axis_tdata[16*k +: 16]);
      end
    end
    peak_d = peak_q;
    if (arm_take) begin
      peak_d = '0;
    end else if (mem_we && (beat_max > peak_q)) begin
      peak_d = beat_max;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_rfdc_dds_capture.sv
// ============================================================================
// tb_rfdc_dds_capture
// ----------------------------------------------------------------------------
// Self-checking bench for rfdc_dds_capture. A small stream model decides
// which driven beats get captured and pushes them, with their expected tlast,
// onto a scoreboard queue; readback handshakes pop and compare.
// ============================================================================
module tb_rfdc_dds_capture;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int TS_W   = 64;

  logic              clk = 1'b0;
  logic              rstn;
  logic [255:0]      s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [TS_W-1:0]   timestamp;
  logic              arm;
  logic              abort;
  logic [TS_W-1:0]   trigger_time;
  logic [ADDR_W:0]   capture_len;
  logic              busy;
  logic              done;
  logic [TS_W-1:0]   trig_timestamp;
  logic [15:0]       gap_count;
  logic [255:0]      m_rd_tdata;
  logic              m_rd_tvalid;
  logic              m_rd_tready;
  logic              m_rd_tlast;

  always #5 clk = ~clk;

  rfdc_dds_capture #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .TS_W   (TS_W)
  ) dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rstn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .timestamp      (timestamp),
    .arm            (arm),
    .abort          (abort),
    .trigger_time   (trigger_time),
    .capture_len    (capture_len),
    .busy           (busy),
    .done           (done),
    .trig_timestamp (trig_timestamp),
    .gap_count      (gap_count),
    .m_rd_tdata     (m_rd_tdata),
    .m_rd_tvalid    (m_rd_tvalid),
    .m_rd_tready    (m_rd_tready),
    .m_rd_tlast     (m_rd_tlast)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entries: {tlast, tdata}
  logic [256:0] sb_q[$];

  // Stream model: 0 idle, 1 armed, 2 capturing, 3 complete
  int          m_phase = 0;
  int          m_len   = 0;
  int          m_idx   = 0;
  int          m_gap   = 0;
  logic [63:0] m_trig  = '0;
  logic [63:0] m_trig_ts = '0;
  bit          m_trig_now = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push();
    logic [256:0] e;
    e = {(m_idx == m_len - 1), {4{timestamp}}};
    sb_q.push_back(e);
  endtask

  // Present one cycle of stream input, update the model, advance one edge.
  task automatic step(input bit v);
    s_axis_tvalid = v;
    s_axis_tdata  = {4{timestamp}};
    m_trig_now    = 1'b0;
    if (m_phase == 1) begin
      if (v && timestamp >= m_trig) begin
        m_idx = 0;
        sb_push();
        m_trig_ts  = timestamp;
        m_trig_now = 1'b1;
        m_idx      = 1;
        m_phase    = (m_len == 1) ? 3 : 2;
      end
    end else if (m_phase == 2) begin
      if (v) begin
        sb_push();
        m_idx++;
        if (m_idx == m_len) m_phase = 3;
      end else begin
        m_gap++;
      end
    end
    @(posedge clk);
    #1;
    timestamp = timestamp + 64'd1;
  endtask

  task automatic do_arm(input logic [63:0] trig, input int len);
    arm          = 1'b1;
    trigger_time = trig;
    capture_len  = (ADDR_W+1)'(len);
    step(1'b1);
    arm     = 1'b0;
    m_phase = 1;
    m_trig  = trig;
    m_len   = (len == 0 || len > DEPTH) ? DEPTH : len;
    m_gap   = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      step(1'b1);
      if (done) got = 1'b1;
    end
    if (!got) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_tready"}, s_axis_tready, 0);
    check({tag, "_trigts"}, trig_timestamp, 0);
    check({tag, "_gap"},    gap_count, 0);
    check({tag, "_rvalid"}, m_rd_tvalid, 0);
    check({tag, "_rlast"},  m_rd_tlast, 0);
    check({tag, "_rdata"},  m_rd_tdata, 0);
  endtask

  // mode 0: tready held high; mode 1: tready pattern 1,0,0,1 repeating.
  // stop_after > 0 ends after that many handshakes (used to reset mid-READ).
  task automatic readback(input string tag, input int mode, input int stop_after);
    int           cyc = 0;
    int           first = -1;
    int           hs = 0;
    bit           fin = 1'b0;
    bit           stalled = 1'b0;
    logic [255:0] sd = '0;
    logic         sl = 1'b0;
    logic [256:0] e;
    while (!fin && cyc < 2000) begin
      m_rd_tready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (stalled) begin
        check({tag, "_stall_data"}, m_rd_tdata, sd);
        check({tag, "_stall_last"}, m_rd_tlast, sl);
      end
      stalled = 1'b0;
      if (m_rd_tvalid) begin
        if (first < 0) begin
          first = cyc;
          check({tag, "_rd_latency"}, cyc, 2);
        end
        if (m_rd_tready) begin
          if (sb_q.size() == 0) begin
            check({tag, "_rd_extra"}, 1, 0);
          end else begin
            e = sb_q.pop_front();
            check({tag, "_rd_data"}, m_rd_tdata, e[255:0]);
            check({tag, "_rd_last"}, m_rd_tlast, e[256]);
          end
          hs++;
          if (m_rd_tlast || hs == stop_after) fin = 1'b1;
        end else begin
          stalled = 1'b1;
          sd = m_rd_tdata;
          sl = m_rd_tlast;
        end
      end else if (mode == 0 && first >= 0) begin
        check({tag, "_rd_bubble"}, m_rd_tvalid, 1);
      end
      step(1'b1);
      cyc++;
    end
    m_rd_tready = 1'b0;
    if (!fin) check({tag, "_rd_timeout"}, 0, 1);
    if (stop_after <= 0) begin
      check({tag, "_rvalid_after"}, m_rd_tvalid, 0);
      check({tag, "_done_after"},   done, 0);
      check({tag, "_sb_left"},      sb_q.size(), 0);
    end
  endtask

  initial begin
    int pos;
    bit got;
    bit v;

    rstn          = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    timestamp     = '0;
    arm           = 1'b0;
    abort         = 1'b0;
    trigger_time  = '0;
    capture_len   = '0;
    m_rd_tready   = 1'b0;

    // Reset state
    repeat (3) step(1'b0);
    check_reset_vals("rst0");
    rstn = 1'b1;
    step(1'b0);
    check("rst0_tready_on", s_axis_tready, 1);

    // Test 1: trigger at 100, 4 beats, armed at ts=10
    timestamp = 64'd0;
    while (timestamp != 64'd10) step(1'b1);
    do_arm(64'd100, 4);
    check("t1_busy", busy, 1);
    wait_done("t1", 300);
    check("t1_trig_ts", trig_timestamp, 100);
    check("t1_gap", gap_count, 0);
    check("t1_busy_done", busy, 0);
    readback("t1", 0, -1);

    // Test 2: trigger time already past when armed at ts=50
    timestamp = 64'd40;
    while (timestamp != 64'd50) step(1'b1);
    do_arm(64'd5, 2);
    wait_done("t2", 50);
    check("t2_trig_ts", trig_timestamp, 51);
    readback("t2", 0, -1);

    // Test 3: 8 beats with three isolated tvalid-low cycles
    do_arm(timestamp + 64'd3, 8);
    pos = -1;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      v = !(pos == 1 || pos == 4 || pos == 7);
      step(v);
      if (m_trig_now) pos = 0;
      else if (pos >= 0) pos++;
      if (done) begin
        got = 1'b1;
        check("t3_done_latency", pos, 11);
      end
    end
    if (!got) check("t3_done_timeout", 0, 1);
    check("t3_gap", gap_count, 3);
    check("t3_gap_model", gap_count, m_gap);
    readback("t3", 0, -1);

    // Test 4: capture_len 0 and DEPTH+5 both capture DEPTH beats
    do_arm(timestamp, 0);
    wait_done("t4a", 600);
    readback("t4a", 0, -1);
    do_arm(timestamp, DEPTH + 5);
    wait_done("t4b", 600);
    readback("t4b", 0, -1);

    // Test 5: readback with tready toggling 1,0,0,1
    do_arm(timestamp + 64'd2, 6);
    wait_done("t5", 50);
    readback("t5", 1, -1);

    // Test 6a: abort mid-capture
    do_arm(timestamp + 64'd2, 8);
    repeat (5) step(1'b1);
    check("t6_busy_pre", busy, 1);
    m_phase = 0;
    sb_q.delete();
    abort = 1'b1;
    step(1'b1);
    abort = 1'b0;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_done", done, 0);
    check("t6_abort_rvalid", m_rd_tvalid, 0);
    check("t6_abort_trigts", trig_timestamp, m_trig_ts);
    check("t6_abort_gap", gap_count, m_gap);

    // Test 6b: arm and abort together, abort wins
    arm          = 1'b1;
    abort        = 1'b1;
    trigger_time = timestamp;
    capture_len  = 9'd4;
    step(1'b1);
    arm   = 1'b0;
    abort = 1'b0;
    step(1'b1);
    check("t6_armabort_busy", busy, 0);
    check("t6_armabort_done", done, 0);

    // Test 6c: reset mid-READ, then a normal capture
    do_arm(timestamp + 64'd1, 5);
    wait_done("t6c", 50);
    readback("t6c", 0, 2);
    rstn    = 1'b0;
    m_phase = 0;
    sb_q.delete();
    step(1'b1);
    check_reset_vals("rst1");
    rstn = 1'b1;
    step(1'b1);
    check("rst1_tready_on", s_axis_tready, 1);
    do_arm(timestamp + 64'd1, 3);
    wait_done("t6d", 50);
    check("t6d_trig_ts", trig_timestamp, m_trig_ts);
    readback("t6d", 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
